// File: rtl/npm_toggle_po_reset_gen.sv
// PHY-output reset pulse generator: drives a masked per-channel pulse of programmable
// length, then an optional deasserted guard interval, using the NPM ready/last-step handshake.
module npm_toggle_po_reset_gen #(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 iSystemClock,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic [NUM_CH-1:0]    iChannelMask,
    input  logic [CNT_WIDTH-1:0] iPulseLength,
    input  logic [CNT_WIDTH-1:0] iGuardLength,
    output logic                 oReady,
    output logic                 oLastStep,
    output logic [NUM_CH-1:0]    oPO_Reset
);

    typedef enum logic [3:0] {
        S_RESET = 4'b0001,
        S_READY = 4'b0010,
        S_PULSE = 4'b0100,
        S_GUARD = 4'b1000
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   guard_q, guard_d;
    logic [NUM_CH-1:0]      mask_q, mask_d;
    logic [NUM_CH-1:0]      po_q, po_d;

    logic                   cnt_zero;
    logic                   last_step;
    logic                   ready;
    logic                   accept;
    logic [CNT_WIDTH-1:0]   pulse_load;

    assign cnt_zero   = (cnt_q == '0);
    assign last_step  = ((state_q == S_PULSE) && cnt_zero && (guard_q == '0)) ||
                        ((state_q == S_GUARD) && cnt_zero);
    assign ready      = (state_q == S_READY) || last_step;
    assign accept     = ready && iStart && (|iChannelMask);
    // A zero pulse length still yields a one-cycle pulse.
    assign pulse_load = (iPulseLength == '0) ? '0 : (iPulseLength - CNT_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        guard_d = guard_q;
        mask_d  = mask_q;

        case (state_q)
            S_RESET: state_d = S_READY;
            S_READY: begin
                if (accept) begin
                    state_d = S_PULSE;
                    cnt_d   = pulse_load;
                    guard_d = iGuardLength;
                    mask_d  = iChannelMask;
                end
            end
            S_PULSE: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (guard_q != '0) begin
                    state_d = S_GUARD;
                    cnt_d   = guard_q - CNT_ONE;
                end else if (accept) begin
                    state_d = S_PULSE;
                    cnt_d   = pulse_load;
                    guard_d = iGuardLength;
                    mask_d  = iChannelMask;
                end else begin
                    state_d = S_READY;
                end
            end
            S_GUARD: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (accept) begin
                    state_d = S_PULSE;
                    cnt_d   = pulse_load;
                    guard_d = iGuardLength;
                    mask_d  = iChannelMask;
                end else begin
                    state_d = S_READY;
                end
            end
            default: state_d = S_RESET;
        endcase

        po_d = (state_d == S_PULSE) ? mask_d : '0;
    end

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            guard_q <= '0;
            mask_q  <= '0;
            po_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            guard_q <= guard_d;
            mask_q  <= mask_d;
            po_q    <= po_d;
        end
    end

    assign oReady    = ready;
    assign oLastStep = last_step;
    assign oPO_Reset = po_q;

endmodule

// File: tb/tb_npm_toggle_po_reset_gen.sv
// Bench for npm_toggle_po_reset_gen: directed and random commands checked each cycle
// against a timestamp-based model of pulse and guard windows.
module tb_npm_toggle_po_reset_gen;

    logic       iSystemClock = 1'b0;
    logic       iReset       = 1'b1;
    logic       iStart       = 1'b0;
    logic [1:0] iChannelMask = 2'b00;
    logic [7:0] iPulseLength = 8'd0;
    logic [7:0] iGuardLength = 8'd0;
    logic       oReady;
    logic       oLastStep;
    logic [1:0] oPO_Reset;

    int total = 0;
    int bad   = 0;

    // Reference model: a command is a start cycle plus pulse/guard durations.
    int         cyc       = 0;
    bit         rst_state = 1'b1;
    bit         active    = 1'b0;
    int         t0, mL, mG;
    logic [1:0] mMask;
    int         pulse_cnt;

    npm_toggle_po_reset_gen #(.NUM_CH(2), .CNT_WIDTH(8)) dut (
        .iSystemClock (iSystemClock),
        .iReset       (iReset),
        .iStart       (iStart),
        .iChannelMask (iChannelMask),
        .iPulseLength (iPulseLength),
        .iGuardLength (iGuardLength),
        .oReady       (oReady),
        .oLastStep    (oLastStep),
        .oPO_Reset    (oPO_Reset)
    );

    always #5 iSystemClock = ~iSystemClock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit s, input logic [1:0] mk, input int pl, input int gl, input bit r);
        logic [1:0] e_po;
        bit         e_rdy, e_last;
        int         k;
        @(posedge iSystemClock);
        #1;
        iStart       = s;
        iChannelMask = mk;
        iPulseLength = pl[7:0];
        iGuardLength = gl[7:0];
        iReset       = r;
        e_po = 2'b00; e_rdy = 1'b0; e_last = 1'b0;
        if (r) begin
            rst_state = 1'b1;
            active    = 1'b0;
        end else if (!rst_state) begin
            if (active) begin
                k      = cyc - t0;
                e_po   = (k >= 1 && k <= mL) ? mMask : 2'b00;
                e_last = (k == mL + mG);
                e_rdy  = e_last;
            end else begin
                e_rdy = 1'b1;
            end
        end
        #1;
        chk("po_reset", oPO_Reset, e_po);
        chk("ready", oReady, e_rdy);
        chk("last_step", oLastStep, e_last);
        if (oPO_Reset == 2'b11) pulse_cnt++;
        if (!r && rst_state) begin
            rst_state = 1'b0;
        end else if (e_rdy && s && mk != 2'b00) begin
            active = 1'b1;
            t0     = cyc;
            mL     = (pl[7:0] == 8'd0) ? 1 : int'(pl[7:0]);
            mG     = int'(gl[7:0]);
            mMask  = mk;
        end else if (active && e_last) begin
            active = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 0, 0, 1'b0);
    endtask

    initial begin
        // Reset and the one-cycle RESET state before READY
        step(1'b0, 2'b00, 0, 0, 1'b1);
        step(1'b0, 2'b00, 0, 0, 1'b1);
        step(1'b0, 2'b00, 0, 0, 1'b0);
        idle(2);

        // Legacy fixed 10-cycle pulse on both channels
        pulse_cnt = 0;
        step(1'b1, 2'b11, 10, 0, 1'b0);
        idle(12);
        chk("legacy_len", pulse_cnt, 10);

        // Masked pulse followed by a guard interval
        step(1'b1, 2'b10, 3, 4, 1'b0);
        idle(9);

        // Zero length behaves as one cycle; zero mask is ignored
        step(1'b1, 2'b01, 0, 0, 1'b0);
        idle(2);
        step(1'b1, 2'b00, 5, 5, 1'b0);
        idle(3);

        // Maximum pulse length
        pulse_cnt = 0;
        step(1'b1, 2'b11, 255, 0, 1'b0);
        idle(258);
        chk("max_len", pulse_cnt, 255);

        // Back-to-back with start held; mask change mid-command applies to the next one
        for (int i = 0; i < 7; i++) step(1'b1, 2'b01, 2, 0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 2'b10, 2, 0, 1'b0);
        idle(3);

        // Reset in the middle of a 10-cycle pulse, then a full pulse afterwards
        step(1'b1, 2'b11, 10, 0, 1'b0);
        step(1'b0, 2'b11, 10, 0, 1'b0);
        step(1'b0, 2'b11, 10, 0, 1'b1);
        step(1'b0, 2'b00, 0, 0, 1'b1);
        step(1'b0, 2'b00, 0, 0, 1'b0);
        pulse_cnt = 0;
        step(1'b1, 2'b11, 10, 0, 1'b0);
        step(1'b1, 2'b11, 10, 0, 1'b0);
        idle(12);
        chk("post_reset_len", pulse_cnt, 10);

        // Random traffic, including back-to-back starts and occasional resets
        for (int i = 0; i < 1500; i++) begin
            bit         s, r;
            logic [1:0] mk;
            int         pl, gl;
            s  = ($urandom_range(0, 2) == 0);
            mk = 2'($urandom_range(0, 3));
            pl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 5));
            gl = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 6));
            r  = ($urandom_range(0, 149) == 0);
            step(s, mk, pl, gl, r);
        end
        idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npm_toggle_po_reset_gen.md
# npm_toggle_po_reset_gen

Parametrised PHY-output reset pulse generator for the Toggle NAND physical module (NPM) layer. On a start command it drives a per-channel PO reset pulse of programmable length, then holds a programmable guard interval before reporting completion. It uses the same oReady/oLastStep handshake as the other NPM primitives. With mask = all ones, pulse length 10 and guard 0, it reproduces the legacy fixed 10-cycle single-pulse behaviour.

## Interface
- NUM_CH, 2, number of independent PO reset outputs (1..16)
- CNT_WIDTH, 8, width of the pulse/guard length fields and the internal counter
- iSystemClock  in  1  system clock; all logic on rising edge
- iReset  in  1  asynchronous, active-high reset
- iStart  in  1  command strobe; sampled only when oReady=1
- iChannelMask  in  NUM_CH  channels to pulse; latched with iStart
- iPulseLength  in  CNT_WIDTH  pulse cycles; 0 is treated as 1; latched with iStart
- iGuardLength  in  CNT_WIDTH  deasserted cycles after the pulse; 0 means no guard; latched with iStart
- oReady  out  1  accepting a command (READY state, or the last cycle of the current command)
- oLastStep  out  1  final cycle of the current command
- oPO_Reset  out  NUM_CH  registered per-channel reset pulse

## Operation
- One-hot FSM with four states: RESET, READY, PULSE, GUARD.
- RESET -> READY unconditionally, after one cycle.
- READY:
  - iStart=1 and iChannelMask!=0 -> latch mask, L=max(iPulseLength,1) and G=iGuardLength; go to PULSE.
  - iStart=1 with mask=0 -> ignored; stay in READY, no pulse.
- PULSE:
  - oPO_Reset = latched mask; all other bits 0.
  - Down-counter loaded with L-1 on entry, decrements each cycle.
  - At count 0: if G=0 the command completes, otherwise go to GUARD with the counter loaded to G-1.
- GUARD:
  - oPO_Reset = 0; counter decrements.
  - At count 0 the command completes.
- Completion cycle:
  - oLastStep=1, combinational from state and counter==0.
  - If iStart=1 with a nonzero mask in that cycle, relatch the inputs and go straight to PULSE (back-to-back, no idle cycle).
  - Otherwise go to READY.
- iStart outside READY or the completion cycle is ignored.
- iChannelMask and the length inputs have no effect while a command is in flight.
- Outputs other than oLastStep/oReady are registers written from the next-state decode.
- Counter arithmetic: unsigned CNT_WIDTH bits; it never wraps, because it is reloaded on every phase entry.
- Reset values: oPO_Reset=0, oReady=0, oLastStep=0, internal counter=0, latched mask=0.
- Reset mid-pulse: oPO_Reset drops to 0 asynchronously. The FSM returns to RESET and re-enters READY one cycle after iReset deasserts.

## Timing
- iStart accepted at edge T (oReady=1).
- oPO_Reset=mask during cycles T+1 .. T+L.
- Guard during cycles T+L+1 .. T+L+G.
- oLastStep=oReady=1 in cycle T+L+G; total command latency is L+G cycles.
- First cycle after iReset deassertion: oReady=0. Second cycle: oReady=1.
- Back-to-back commands: the new pulse starts in the cycle after the old oLastStep. With G=0 the oPO_Reset bit of a channel in both masks stays continuously high.
- Maximum command length is 2^CNT_WIDTH-1 + 2^CNT_WIDTH-1 cycles.

## Test plan
- Legacy: mask=2'b11, L=10, G=0, iStart at T -> oPO_Reset=2'b11 for exactly T+1..T+10; oLastStep and oReady high only in T+10; oReady=0 during T+1..T+9.
- Guard and mask: mask=2'b10, L=3, G=4 -> oPO_Reset=2'b10 at T+1..T+3, then 2'b00 at T+4..T+7; oLastStep at T+7 only.
- Boundaries:
  - L=0, G=0 -> one-cycle pulse at T+1 with oLastStep at T+1.
  - mask=0 -> no pulse; oReady stays 1.
  - L=255 (CNT_WIDTH=8) -> exactly 255 pulse cycles.
- Back-to-back: iStart held high with mask=2'b01, L=2, G=0 -> pulse continuous on ch0; oLastStep every 2nd cycle. Changing iChannelMask mid-command to 2'b10 takes effect only on the next command.
- Reset mid-operation: assert iReset at T+2 of an L=10 command -> oPO_Reset=0 immediately; after deassert, oReady=0 for one cycle then 1; a new iStart gives a full 10-cycle pulse.
